// File: rtl/hdmi_pkg.sv
// Shared constants and types for the video timing blocks.
// Holds the default counter width, sync polarity constants and the
// index type that names each field of the timing bundle.
package hdmi_pkg;

    // Default width of every timing field and position counter.
    localparam int SYNCGEN_NBITS = 16;

    // Sync polarity selectors: value XORed onto an active-high sync.
    localparam logic SYNC_POS = 1'b0;
    localparam logic SYNC_NEG = 1'b1;

    // Timing bundle: eight NBITS-wide fields packed into
    // logic [NUM_TIMING-1:0][NBITS-1:0], addressed by timing_field_e.
    localparam int NUM_TIMING = 8;

    typedef enum logic [2:0] {
        TF_HM_WIDTH  = 3'd0,
        TF_HM_PORCH  = 3'd1,
        TF_HM_SYNCH  = 3'd2,
        TF_HM_RAW    = 3'd3,
        TF_VM_HEIGHT = 3'd4,
        TF_VM_PORCH  = 3'd5,
        TF_VM_SYNCH  = 3'd6,
        TF_VM_RAW    = 3'd7
    } timing_field_e;

endpackage

// File: rtl/syncgen_axis.sv
// One axis of the sync generator: a position counter that wraps at
// raw-1 (or immediately when it has been left past a shrunken total),
// plus the active-region and sync-window decode of the position that
// will be presented after the next clock edge.
module syncgen_axis #(
    parameter int NBITS = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_adv,
    input  logic [NBITS-1:0] i_raw,
    input  logic [NBITS-1:0] i_width,
    input  logic [NBITS-1:0] i_porch,
    input  logic [NBITS-1:0] i_synch,
    output logic [NBITS-1:0] o_pos,
    output logic             o_last,
    output logic             o_act_next,
    output logic             o_win_next
);

    logic [NBITS-1:0] r_pos;
    logic [NBITS-1:0] w_pos_next;
    logic             w_last;

    // Last position: at or beyond raw-1; a raw of 0 or 1 pins the counter at 0.
    always_comb begin
        w_last     = (i_raw <= NBITS'(1)) || (r_pos >= (i_raw - NBITS'(1)));
        w_pos_next = r_pos;
        if (i_adv) begin
            w_pos_next = w_last ? '0 : (r_pos + NBITS'(1));
        end
    end

    // Position register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pos <= '0;
        end else begin
            r_pos <= w_pos_next;
        end
    end

    assign o_pos      = r_pos;
    assign o_last     = w_last;
    // An empty window (porch >= synch) can never satisfy both bounds.
    assign o_act_next = (w_pos_next < i_width);
    assign o_win_next = (w_pos_next >= i_porch) && (w_pos_next < i_synch);

endmodule

// File: rtl/syncgen.sv
// Video sync generator: horizontal/vertical position counters with
// registered data-enable, sync and line/frame-start outputs that all
// describe the presented position.
// Optional macro SYNCGEN_SHADOW_EN: timing inputs are latched on reset
// and at each wrap into (0,0), so live edits apply from the next frame.
module syncgen
    import hdmi_pkg::*;
#(
    parameter int   NBITS     = SYNCGEN_NBITS,
    parameter logic HSYNC_NEG = SYNC_POS,
    parameter logic VSYNC_NEG = SYNC_POS
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [NBITS-1:0] i_hm_width,
    input  logic [NBITS-1:0] i_hm_porch,
    input  logic [NBITS-1:0] i_hm_synch,
    input  logic [NBITS-1:0] i_hm_raw,
    input  logic [NBITS-1:0] i_vm_height,
    input  logic [NBITS-1:0] i_vm_porch,
    input  logic [NBITS-1:0] i_vm_synch,
    input  logic [NBITS-1:0] i_vm_raw,
    output logic [NBITS-1:0] o_hpos,
    output logic [NBITS-1:0] o_vpos,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_newline,
    output logic             o_newframe
);

    logic [NUM_TIMING-1:0][NBITS-1:0] w_live;
    logic [NUM_TIMING-1:0][NBITS-1:0] w_cur;   // drives the wrap decisions
    logic [NUM_TIMING-1:0][NBITS-1:0] w_next;  // drives the decode of the next position

    logic             r_run;
    logic             r_de;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_newline;
    logic             r_newframe;

    logic             w_h_adv;
    logic             w_h_last;
    logic             w_h_wrap;
    logic             w_v_last;
    logic             w_frame_wrap;
    logic             w_h_act;
    logic             w_h_win;
    logic             w_v_act;
    logic             w_v_win;
    logic [NBITS-1:0] w_hpos;
    logic [NBITS-1:0] w_vpos;

    assign w_live[TF_HM_WIDTH]  = i_hm_width;
    assign w_live[TF_HM_PORCH]  = i_hm_porch;
    assign w_live[TF_HM_SYNCH]  = i_hm_synch;
    assign w_live[TF_HM_RAW]    = i_hm_raw;
    assign w_live[TF_VM_HEIGHT] = i_vm_height;
    assign w_live[TF_VM_PORCH]  = i_vm_porch;
    assign w_live[TF_VM_SYNCH]  = i_vm_synch;
    assign w_live[TF_VM_RAW]    = i_vm_raw;

    // Counting only resumes once the held position has been re-presented,
    // so the first enabled cycle after reset or a pause shows the held point.
    assign w_h_adv      = i_en && r_run;
    assign w_h_wrap     = w_h_adv && w_h_last;
    assign w_frame_wrap = w_h_wrap && w_v_last;

`ifdef SYNCGEN_SHADOW_EN
    logic [NUM_TIMING-1:0][NBITS-1:0] r_shadow;

    assign w_cur  = r_shadow;
    assign w_next = (i_reset || w_frame_wrap) ? w_live : r_shadow;

    // Shadow timing: reloaded on reset and on every wrap into (0,0).
    always_ff @(posedge i_clk) begin
        r_shadow <= w_next;
    end
`else
    assign w_cur  = w_live;
    assign w_next = w_live;
`endif

    syncgen_axis #(.NBITS(NBITS)) u_haxis (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_adv      (w_h_adv),
        .i_raw      (w_cur[TF_HM_RAW]),
        .i_width    (w_next[TF_HM_WIDTH]),
        .i_porch    (w_next[TF_HM_PORCH]),
        .i_synch    (w_next[TF_HM_SYNCH]),
        .o_pos      (w_hpos),
        .o_last     (w_h_last),
        .o_act_next (w_h_act),
        .o_win_next (w_h_win)
    );

    syncgen_axis #(.NBITS(NBITS)) u_vaxis (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_adv      (w_h_wrap),
        .i_raw      (w_cur[TF_VM_RAW]),
        .i_width    (w_next[TF_VM_HEIGHT]),
        .i_porch    (w_next[TF_VM_PORCH]),
        .i_synch    (w_next[TF_VM_SYNCH]),
        .o_pos      (w_vpos),
        .o_last     (w_v_last),
        .o_act_next (w_v_act),
        .o_win_next (w_v_win)
    );

    // Registered decode of the position being loaded into the counters;
    // everything is forced inactive while paused.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run      <= 1'b0;
            r_de       <= 1'b0;
            r_hsync    <= HSYNC_NEG;
            r_vsync    <= VSYNC_NEG;
            r_newline  <= 1'b0;
            r_newframe <= 1'b0;
        end else begin
            r_run      <= i_en;
            r_de       <= i_en && w_h_act && w_v_act;
            r_hsync    <= (i_en && w_h_win) ^ HSYNC_NEG;
            r_vsync    <= (i_en && w_v_win) ^ VSYNC_NEG;
            // Next hpos is 0 either by a line wrap or by re-presenting a held 0.
            r_newline  <= i_en && (w_h_wrap || (!w_h_adv && (w_hpos == '0)));
            r_newframe <= i_en && (w_frame_wrap ||
                          (!w_h_adv && (w_hpos == '0) && (w_vpos == '0)));
        end
    end

    assign o_hpos     = w_hpos;
    assign o_vpos     = w_vpos;
    assign o_de       = r_de;
    assign o_hsync    = r_hsync;
    assign o_vsync    = r_vsync;
    assign o_newline  = r_newline;
    assign o_newframe = r_newframe;

endmodule

// File: tb/tb_syncgen.sv
// Directed testbench for syncgen with a small 10x5 raster.
// A second instance with an active-low hsync shares all inputs.
module tb_syncgen;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] hm_width, hm_porch, hm_synch, hm_raw;
    logic [15:0] vm_height, vm_porch, vm_synch, vm_raw;

    logic [15:0] hpos, vpos, n_hpos, n_vpos;
    logic        de, hs, vs, nl, nf;
    logic        n_de, n_hs, n_vs, n_nl, n_nf;

    int errors = 0;
    int checks = 0;
    int exp_h;
    int exp_v;
    bit hs_empty;

    always #5 clk = ~clk;

    syncgen #(.NBITS(16), .HSYNC_NEG(1'b0), .VSYNC_NEG(1'b0)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_en(en),
        .i_hm_width(hm_width), .i_hm_porch(hm_porch), .i_hm_synch(hm_synch), .i_hm_raw(hm_raw),
        .i_vm_height(vm_height), .i_vm_porch(vm_porch), .i_vm_synch(vm_synch), .i_vm_raw(vm_raw),
        .o_hpos(hpos), .o_vpos(vpos), .o_de(de), .o_hsync(hs), .o_vsync(vs),
        .o_newline(nl), .o_newframe(nf)
    );

    syncgen #(.NBITS(16), .HSYNC_NEG(1'b1), .VSYNC_NEG(1'b0)) u_neg (
        .i_clk(clk), .i_reset(rst), .i_en(en),
        .i_hm_width(hm_width), .i_hm_porch(hm_porch), .i_hm_synch(hm_synch), .i_hm_raw(hm_raw),
        .i_vm_height(vm_height), .i_vm_porch(vm_porch), .i_vm_synch(vm_synch), .i_vm_raw(vm_raw),
        .o_hpos(n_hpos), .o_vpos(n_vpos), .o_de(n_de), .o_hsync(n_hs), .o_vsync(n_vs),
        .o_newline(n_nl), .o_newframe(n_nf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (hpos=%0d vpos=%0d)", tag, obs, exp, exp_h, exp_v);
        end
    endtask

    // Outputs are sampled on the falling edge, half a period after the update.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_run();
        bit hsx;
        hsx = !hs_empty && (exp_h == 7 || exp_h == 8);
        check("hpos",     hpos,  exp_h);
        check("vpos",     vpos,  exp_v);
        check("de",       de,    (exp_h < 6) && (exp_v < 3));
        check("hsync",    hs,    hsx);
        check("hsync_n",  n_hs,  !hsx);
        check("vsync",    vs,    exp_v == 4);
        check("newline",  nl,    exp_h == 0);
        check("newframe", nf,    (exp_h == 0) && (exp_v == 0));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_hpos"},     hpos, 0);
        check({tag, "_vpos"},     vpos, 0);
        check({tag, "_de"},       de,   0);
        check({tag, "_hsync"},    hs,   0);
        check({tag, "_hsync_n"},  n_hs, 1);
        check({tag, "_vsync"},    vs,   0);
        check({tag, "_newline"},  nl,   0);
        check({tag, "_newframe"}, nf,   0);
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            exp_h++;
            if (exp_h == 10) begin
                exp_h = 0;
                exp_v++;
                if (exp_v == 5) exp_v = 0;
            end
            check_run();
        end
    endtask

    initial begin
        hm_width = 16'd6;  hm_porch = 16'd7; hm_synch = 16'd9; hm_raw = 16'd10;
        vm_height = 16'd3; vm_porch = 16'd4; vm_synch = 16'd5; vm_raw = 16'd5;
        hs_empty = 1'b0;
        exp_h = 0;
        exp_v = 0;
        en  = 1'b1;
        rst = 1'b1;

        // Reset state
        step();
        step();
        check_reset("rst");

        // Release: first enabled cycle shows (0,0) with newframe
        rst = 1'b0;
        step();
        check_run();

        // One full 50-cycle frame back to (0,0)
        adv(50);
        check("frame_newframe", nf, 1);

        // Pause for 3 cycles at hpos=4
        adv(4);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause_hpos",     hpos, 4);
            check("pause_vpos",     vpos, 0);
            check("pause_de",       de,   0);
            check("pause_hsync",    hs,   0);
            check("pause_hsync_n",  n_hs, 1);
            check("pause_vsync",    vs,   0);
            check("pause_newline",  nl,   0);
            check("pause_newframe", nf,   0);
        end
        en = 1'b1;
        step();
        check_run();              // hpos=4 re-presented
        adv(1);                   // then 5

        // Reset mid-frame at (3,2)
        adv(18);
        rst = 1'b1;
        step();
        check_reset("midrst");
        rst = 1'b0;
        step();
        exp_h = 0;
        exp_v = 0;
        check_run();

        // Live shrink of hraw while hpos=8
        adv(8);
        hm_raw = 16'd5;
        step();
`ifdef SYNCGEN_SHADOW_EN
        exp_h = 9;
        exp_v = 0;
`else
        exp_h = 0;
        exp_v = 1;
`endif
        check_run();
        hm_raw = 16'd10;
        adv(3);

        // Empty hsync window (porch == synch), applied during reset
        rst = 1'b1;
        hm_porch = 16'd7;
        hm_synch = 16'd7;
        hs_empty = 1'b1;
        step();
        check_reset("emptyrst");
        rst = 1'b0;
        step();
        exp_h = 0;
        exp_v = 0;
        check_run();
        adv(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
